// File: rtl/mips_main_ctrl.sv
// mips_main_ctrl
//   Multi-cycle main control sequencer for the MIPS datapath. Each instruction
//   walks FETCH -> DECODE -> EXEC -> [MEM] -> [WB] and the block emits the
//   datapath strobes plus the 5-bit ALU class code for the ALU control decoder.
//   Memory accesses stall on mem_ready. Unsupported opcodes park the sequencer
//   in TRAP until reset.
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   opcode, funct      IR[31:26], IR[5:0]; only looked at in DECODE
//   mem_ready          memory completed the current access this cycle
//   aluOp              ALU class code
//   mem_read/mem_write memory request, held until mem_ready
//   ir_write, pc_write IR load / unconditional PC update (end of FETCH)
//   pc_write_cond      branch-conditional PC update (EXEC of a branch)
//   reg_write          register file write enable (WB)
//   illegal            set while in TRAP
//   instr_done         one-cycle pulse on the last cycle of an instruction
//   state              current state, for debug
module mips_main_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic [4:0] aluOp,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       reg_write,
    output logic       illegal,
    output logic       instr_done,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [4:0] ALU_ADD = 5'b00010;

    state_t     state_q, state_d;
    logic [4:0] cls_q, cls_d;
    // Registers reset release so IDLE lasts one full cycle and the first
    // FETCH starts on the second rising edge after reset_n goes high.
    logic       run_q, run_d;

    logic [4:0] dec_cls;
    logic       dec_ok;
    logic       is_br, is_load, is_store;

    // Class codes group naturally: bit4 = branch, 010xx = load, 011xx = store.
    assign is_br    = cls_q[4];
    assign is_load  = (cls_q[4:2] == 3'b010);
    assign is_store = (cls_q[4:2] == 3'b011);

    // Opcode/funct to class code.
    always_comb begin
        dec_cls = 5'b00000;
        dec_ok  = 1'b1;
        case (opcode)
            6'b000000: dec_cls = 5'b00000;
            6'b011100: begin
                dec_cls = 5'b00001;
                dec_ok  = (funct == 6'b100000) || (funct == 6'b100001);
            end
            6'b001000, 6'b001001: dec_cls = 5'b00010;
            6'b001010, 6'b001011: dec_cls = 5'b00011;
            6'b001100: dec_cls = 5'b00100;
            6'b001101: dec_cls = 5'b00101;
            6'b001110: dec_cls = 5'b00110;
            6'b100011, 6'b100001: dec_cls = 5'b01000;
            6'b100101: dec_cls = 5'b01001;
            6'b100000: dec_cls = 5'b01010;
            6'b100100: dec_cls = 5'b01011;
            6'b111111: dec_cls = 5'b01100;
            6'b101011: dec_cls = 5'b01101;
            6'b101001: dec_cls = 5'b01110;
            6'b101000: dec_cls = 5'b01111;
            6'b000100: dec_cls = 5'b10000;
            6'b000111: dec_cls = 5'b10101;
            6'b000110: dec_cls = 5'b10110;
            default:   dec_ok  = 1'b0;
        endcase
    end

    // Next state / class register.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        run_d   = 1'b1;
        case (state_q)
            S_IDLE:   if (run_q) state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                cls_d   = dec_cls;
                state_d = dec_ok ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                if (is_br)                    state_d = S_FETCH;
                else if (is_load || is_store) state_d = S_MEM;
                else                          state_d = S_WB;
            end
            S_MEM:    if (mem_ready) state_d = is_load ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cls_q   <= 5'b00000;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            run_q   <= run_d;
        end
    end

    // Strobes come from state/class only; mem_ready qualifies the handshake
    // completions. Reset forces state_q to IDLE so every strobe drops at once.
    always_comb begin
        aluOp         = 5'b00000;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        reg_write     = 1'b0;
        illegal       = 1'b0;
        instr_done    = 1'b0;
        case (state_q)
            S_FETCH: begin
                aluOp    = ALU_ADD;
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: aluOp = ALU_ADD;
            S_EXEC: begin
                aluOp         = cls_q;
                pc_write_cond = is_br;
                instr_done    = is_br;
            end
            S_MEM: begin
                aluOp      = cls_q;
                mem_read   = is_load;
                mem_write  = is_store;
                instr_done = is_store && mem_ready;
            end
            S_WB: begin
                aluOp      = cls_q;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: doc/mips_main_ctrl.md
# mips_main_ctrl

Multi-cycle main control unit for the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath strobes and produces the 5-bit `aluOp` class code that the ALU control decoder turns into a 6-bit ALU function. Memory accesses use a ready handshake, so memory wait states stall the sequencer.

## Interface
- No parameters. Encodings are fixed by the ALU control decoder.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: `IR[31:26]`; sampled in DECODE.
- `funct` in 6: `IR[5:0]`; sampled in DECODE, used only for the SPECIAL2 check.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `aluOp` out 5: ALU class code for the ALU control decoder.
- `mem_read`, `mem_write` out 1 each: memory request, held until `mem_ready`.
- `ir_write`, `pc_write`, `pc_write_cond` out 1 each: IR load strobe, unconditional PC update, branch-conditional PC update.
- `reg_write` out 1: register file write enable.
- `illegal` out 1: sticky flag for an unsupported opcode.
- `instr_done` out 1: one-cycle pulse on the last cycle of each instruction.
- `state` out 3: current state, for debug.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- IDLE: all outputs 0 and `aluOp`=00000. Always goes to FETCH on the next cycle.
- FETCH:
  - `mem_read`=1, `aluOp`=00010 (PC+4).
  - Stays while `mem_ready`=0.
  - On the cycle `mem_ready`=1: `ir_write`=1 and `pc_write`=1, then go to DECODE.
- DECODE:
  - `aluOp`=00010 (branch target add).
  - Latches a class register from `opcode`/`funct`, then goes to EXEC, or to TRAP if the opcode is unsupported.
- Class to `aluOp` map (opcode binary):
  - `000000` R-type: 00000.
  - `011100` with funct `100000`/`100001` (CLZ/CLO): 00001. Any other funct here is illegal.
  - `001000`/`001001`: 00010. `001010`/`001011`: 00011.
  - `001100`: 00100. `001101`: 00101. `001110`: 00110.
  - `100011` LW and `100001` LH: 01000. `100101` LHU: 01001. `100000` LB: 01010. `100100` LBU: 01011.
  - `111111` SD: 01100. `101011` SW: 01101. `101001` SH: 01110. `101000` SB: 01111.
  - `000100` BEQ/B: 10000. `000111` BGTZ: 10101. `000110` BLEZ: 10110.
  - Any other opcode is illegal.
- EXEC drives the latched class `aluOp`. Next state depends on the class:
  - Branch: `pc_write_cond`=1 and `instr_done`=1, then FETCH.
  - ALU class (R-type, CLx, immediate): go to WB.
  - Load or store: go to MEM.
- MEM:
  - Keeps the class `aluOp` so the address stays stable.
  - Drives `mem_read` for a load or `mem_write` for a store, held until `mem_ready`=1.
  - Load then goes to WB. Store pulses `instr_done` in that cycle and goes to FETCH.
- WB: `reg_write`=1, `instr_done`=1, `aluOp` = class code, then FETCH.
- TRAP: `illegal`=1, all other strobes 0, `aluOp`=00000. Stays in TRAP until reset.
- Strobes are decoded from the state and class registers only, so they never depend combinationally on `opcode`. The one exception is the `mem_ready`-qualified `ir_write`/`pc_write`/`instr_done`.
- `mem_read` and `mem_write` are never both 1.

## Timing
- Reset (asynchronous, any state, including mid-MEM wait): state becomes IDLE immediately, all outputs 0, class register cleared.
- First FETCH begins on the second rising edge after `reset_n` rises.
- Cycle counts with zero wait states (`mem_ready` tied high):
  - Branch: 3 cycles (FETCH, DECODE, EXEC).
  - ALU class and store: 4 cycles.
  - Load: 5 cycles.
- Each cycle with `mem_ready`=0 in FETCH or MEM adds exactly one cycle.
- `mem_ready` is ignored in all other states.
- `instr_done` is high for exactly one cycle per completed instruction, and never in TRAP.

## Test plan
- Reset with `mem_ready`=1: IDLE for 1 cycle, then FETCH with `mem_read`=1 and `aluOp`=00010. Assert reset mid-FETCH: state returns to 0 and all strobes go 0 asynchronously.
- ADDI (`001000`), zero waits: states 1,2,3,5 then 1. EXEC and WB show `aluOp`=00010. `reg_write`=1 only in WB. `instr_done` asserts in the 4th cycle.
- LBU (`100100`) with `mem_ready` low for 2 MEM cycles: `aluOp`=01011 held through MEM, `mem_read` held for 3 cycles, 7 cycles total.
- SB (`101000`): MEM shows `mem_write`=1 and `aluOp`=01111. No WB, `reg_write` never asserts, back to FETCH after MEM.
- BLEZ (`000110`): EXEC shows `aluOp`=10110 and `pc_write_cond`=1, 3 cycles total. Repeat with BGTZ for 10101.
- SPECIAL2 with funct `100001`: `aluOp`=00001 in EXEC. Then opcode `010000` (unsupported): DECODE goes to TRAP, `illegal`=1 held for 20 cycles, no `instr_done`, cleared only by reset.
